// File: rtl/seq_alu_if.sv
// Request/response bundle for seq_alu: operand handshake in, result handshake plus status flags out.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             negative;
  logic             carry;
  logic             overflow;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, negative, carry, overflow
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, negative, carry, overflow
  );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops, iterative shift-add multiply and
// restoring divide (one bit per cycle), valid/ready handshake on both sides.
module seq_alu #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       rst,
  seq_alu_if.slave   bus
);

  localparam logic [3:0] OpAdd   = 4'b0000;
  localparam logic [3:0] OpSub   = 4'b0001;
  localparam logic [3:0] OpAnd   = 4'b0010;
  localparam logic [3:0] OpOr    = 4'b0011;
  localparam logic [3:0] OpSltu  = 4'b0100;
  localparam logic [3:0] OpSlt   = 4'b0101;
  localparam logic [3:0] OpXor   = 4'b0111;
  localparam logic [3:0] OpSll   = 4'b1000;
  localparam logic [3:0] OpSrl   = 4'b1001;
  localparam logic [3:0] OpSra   = 4'b1010;

  localparam logic [SHW:0] CntLast = (SHW+1)'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q, state_d;
  logic [SHW:0]     cnt_q, cnt_d;
  logic [1:0]       md_op_q, md_op_d;  // 00 MUL, 01 MULHU, 10 DIVU, 11 REMU
  logic [WIDTH-1:0] opnd_q, opnd_d;    // multiplicand or divisor
  logic [WIDTH-1:0] hi_q, hi_d;        // product high half / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;        // multiplier / dividend-quotient
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             negative_q, negative_d;
  logic             carry_q, carry_d;
  logic             overflow_q, overflow_d;

  // Single-cycle datapath, evaluated on the live inputs at accept.
  logic             is_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

  always_comb begin
    is_sub  = (bus.op == OpSub);
    b_eff   = is_sub ? ~bus.b : bus.b;
    sum     = {1'b0, bus.a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    shamt   = bus.b[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (bus.op)
      OpAdd, OpSub: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (bus.a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OpAnd:  alu_res = bus.a & bus.b;
      OpOr:   alu_res = bus.a | bus.b;
      OpXor:  alu_res = bus.a ^ bus.b;
      OpSltu: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OpSll:  alu_res = bus.a << shamt;
      OpSrl:  alu_res = bus.a >> shamt;
      OpSra:  alu_res = $unsigned($signed(bus.a) >>> shamt);
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply and of restoring divide.
  logic [WIDTH:0]   mul_add;
  logic [WIDTH-1:0] mul_hi, mul_lo;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] div_diff;
  logic [WIDTH-1:0] div_hi, div_lo;

  always_comb begin
    mul_add  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi   = mul_add[WIDTH:1];
    mul_lo   = {mul_add[0], lo_q[WIDTH-1:1]};
    rem_sh   = {hi_q, lo_q[WIDTH-1]};
    div_diff = {1'b0, rem_sh} - {2'b00, opnd_q};
    // A zero divisor never borrows, so the quotient fills with ones and the remainder
    // ends up equal to the dividend without any special casing.
    if (!div_diff[WIDTH+1]) begin
      div_hi = div_diff[WIDTH-1:0];
      div_lo = {lo_q[WIDTH-2:0], 1'b1};
    end else begin
      div_hi = rem_sh[WIDTH-1:0];
      div_lo = {lo_q[WIDTH-2:0], 1'b0};
    end
  end

  logic             load_res;
  logic [WIDTH-1:0] new_res;
  logic             new_c;
  logic             new_v;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    md_op_d    = md_op_q;
    opnd_d     = opnd_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    result_d   = result_q;
    zero_d     = zero_q;
    negative_d = negative_q;
    carry_d    = carry_q;
    overflow_d = overflow_q;
    load_res   = 1'b0;
    new_res    = '0;
    new_c      = 1'b0;
    new_v      = 1'b0;

    case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          if (bus.op[3:2] == 2'b11) begin
            md_op_d = bus.op[1:0];
            opnd_d  = bus.op[1] ? bus.b : bus.a;
            lo_d    = bus.op[1] ? bus.a : bus.b;
            hi_d    = '0;
            cnt_d   = '0;
            state_d = StCalc;
          end else begin
            load_res = 1'b1;
            new_res  = alu_res;
            new_c    = alu_c;
            new_v    = alu_v;
            state_d  = StDone;
          end
        end
      end
      StCalc: begin
        hi_d  = md_op_q[1] ? div_hi : mul_hi;
        lo_d  = md_op_q[1] ? div_lo : mul_lo;
        cnt_d = cnt_q + {{SHW{1'b0}}, 1'b1};
        if (cnt_q == CntLast) begin
          load_res = 1'b1;
          new_res  = md_op_q[0] ? hi_d : lo_d;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_res) begin
      result_d   = new_res;
      zero_d     = (new_res == '0);
      negative_d = new_res[WIDTH-1];
      carry_d    = new_c;
      overflow_d = new_v;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      md_op_q    <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      md_op_q    <= md_op_d;
      opnd_q     <= opnd_d;
      hi_q       <= hi_d;
      lo_q       <= lo_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      negative_q <= negative_d;
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle) && !rst;
  assign bus.out_valid = (state_q == StDone) && !rst;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.negative  = negative_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: table of op vectors with hand-computed results, flags and
// latency, plus sequences for output back-pressure and reset during a multiply.
module tb_seq_alu;

  localparam int unsigned W = 32;

  logic clk;
  logic rst;

  seq_alu_if #(.WIDTH(W)) bus ();

  seq_alu #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [3:0]   flags;  // {zero, negative, carry, overflow}
    int           lat;
  } vec_t;

  vec_t vecs[26];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] flags_now();
    return {bus.zero, bus.negative, bus.carry, bus.overflow};
  endfunction

  // Issue one request, scramble inputs after accept, wait for out_valid, then drain it.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] res, output logic [3:0] flags,
                        output int lat, output bit ready_low);
    int guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.op       = ~op;
    bus.a        = ~a;
    bus.b        = b ^ 32'h5a5a_5a5a;
    lat       = 1;
    ready_low = 1'b1;
    while (!bus.out_valid && lat < 100) begin
      if (bus.in_ready) ready_low = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    res   = bus.result;
    flags = flags_now();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] res;
    logic [3:0]   flags;
    int           lat;
    bit           ready_low;
    int           guard;
    bit           rose;

    vecs[0]  = '{4'b0000, 32'h7fff_ffff, 32'h0000_0001, 32'h8000_0000, 4'b0101, 1};
    vecs[1]  = '{4'b0001, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1010, 1};
    vecs[2]  = '{4'b0001, 32'h0000_0000, 32'h0000_0001, 32'hffff_ffff, 4'b0100, 1};
    vecs[3]  = '{4'b1010, 32'h8000_0000, 32'h0000_0024, 32'hf800_0000, 4'b0100, 1};
    vecs[4]  = '{4'b1001, 32'h8000_0000, 32'h0000_0024, 32'h0800_0000, 4'b0000, 1};
    vecs[5]  = '{4'b0100, 32'h0000_0001, 32'hffff_ffff, 32'h0000_0001, 4'b0000, 1};
    vecs[6]  = '{4'b0101, 32'h0000_0001, 32'hffff_ffff, 32'h0000_0000, 4'b1000, 1};
    vecs[7]  = '{4'b0101, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0001, 4'b0000, 1};
    vecs[8]  = '{4'b0010, 32'hf0f0_f0f0, 32'hff00_ff00, 32'hf000_f000, 4'b0100, 1};
    vecs[9]  = '{4'b0011, 32'h0f00_0000, 32'h0000_00f0, 32'h0f00_00f0, 4'b0000, 1};
    vecs[10] = '{4'b0111, 32'haaaa_5555, 32'hffff_0000, 32'h5555_5555, 4'b0000, 1};
    vecs[11] = '{4'b1000, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 4'b0000, 1};
    vecs[12] = '{4'b0110, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b1000, 1};
    vecs[13] = '{4'b1011, 32'h1234_5678, 32'h0000_0001, 32'h0000_0000, 4'b1000, 1};
    vecs[14] = '{4'b0000, 32'hffff_ffff, 32'h0000_0001, 32'h0000_0000, 4'b1010, 1};
    vecs[15] = '{4'b0001, 32'h8000_0000, 32'h0000_0001, 32'h7fff_ffff, 4'b0011, 1};
    vecs[16] = '{4'b1100, 32'hffff_ffff, 32'h0000_0002, 32'hffff_fffe, 4'b0100, 33};
    vecs[17] = '{4'b1101, 32'hffff_ffff, 32'h0000_0002, 32'h0000_0001, 4'b0000, 33};
    vecs[18] = '{4'b1110, 32'h0000_0064, 32'h0000_0007, 32'h0000_000e, 4'b0000, 33};
    vecs[19] = '{4'b1111, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 4'b0000, 33};
    vecs[20] = '{4'b1110, 32'h0000_0007, 32'h0000_0000, 32'hffff_ffff, 4'b0100, 33};
    vecs[21] = '{4'b1111, 32'h0000_0007, 32'h0000_0000, 32'h0000_0007, 4'b0000, 33};
    vecs[22] = '{4'b1100, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 4'b0000, 33};
    vecs[23] = '{4'b1110, 32'hffff_ffff, 32'h0000_0010, 32'h0fff_ffff, 4'b0000, 33};
    vecs[24] = '{4'b1111, 32'hffff_ffff, 32'h0000_0010, 32'h0000_000f, 4'b0000, 33};
    vecs[25] = '{4'b1101, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4'b0000, 33};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.op        = 4'b0000;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("reset out_valid", 64'(bus.out_valid), 64'd0);
    check("reset in_ready", 64'(bus.in_ready), 64'd0);
    check("reset result", 64'(bus.result), 64'd0);
    check("reset flags", 64'(flags_now()), 64'd0);
    rst = 1'b0;
    #1;
    check("post-reset in_ready", 64'(bus.in_ready), 64'd1);

    // Vector table
    for (int i = 0; i < 26; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, res, flags, lat, ready_low);
      check($sformatf("vec%0d result", i), 64'(res), 64'(vecs[i].res));
      check($sformatf("vec%0d flags", i), 64'(flags), 64'(vecs[i].flags));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d in_ready low while busy", i), 64'(ready_low), 64'd1);
      check($sformatf("vec%0d out_valid drops", i), 64'(bus.out_valid), 64'd0);
    end

    // Back-pressure in DONE: result/flags hold, a competing request is not taken
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    bus.in_valid = 1'b1;
    bus.op       = 4'b0001;
    bus.a        = 32'h0000_0000;
    bus.b        = 32'h0000_0001;
    @(posedge clk); #1;
    bus.op = 4'b0000;
    bus.a  = 32'h0000_0002;
    bus.b  = 32'h0000_0003;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold%0d out_valid", k), 64'(bus.out_valid), 64'd1);
      check($sformatf("hold%0d result", k), 64'(bus.result), 64'hffff_ffff);
      check($sformatf("hold%0d flags", k), 64'(flags_now()), 64'(4'b0100));
      check($sformatf("hold%0d in_ready", k), 64'(bus.in_ready), 64'd0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check("hold release out_valid", 64'(bus.out_valid), 64'd0);
    check("hold release in_ready", 64'(bus.in_ready), 64'd1);
    check("hold release result kept", 64'(bus.result), 64'hffff_ffff);

    // Reset at cycle 10 of a MUL aborts it
    bus.in_valid = 1'b1;
    bus.op       = 4'b1100;
    bus.a        = 32'h0000_0003;
    bus.b        = 32'h0000_0004;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
    end
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.op       = 4'b0000;
    bus.out_ready = 1'b1;
    #1;
    check("abort in_ready during rst", 64'(bus.in_ready), 64'd0);
    @(posedge clk); #1;
    rst           = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #1;
    check("abort in_ready after rst", 64'(bus.in_ready), 64'd1);
    check("abort result cleared", 64'(bus.result), 64'd0);
    rose = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) rose = 1'b1;
      @(posedge clk); #1;
    end
    check("abort no out_valid", 64'(rose), 64'd0);
    run_op(4'b0000, 32'd2, 32'd3, res, flags, lat, ready_low);
    check("after abort ADD result", 64'(res), 64'd5);
    check("after abort ADD latency", 64'(lat), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
